// File: rtl/conv_mac_stream.sv
// conv_mac_stream: serial multiply-accumulate convolution engine.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and while a result is offered but
// not taken the whole pipeline freezes (o_tap_ready = 0).
// One tap per cycle enters a registered product stage. The accumulator
// folds the products, and the last product of a window is rounded, clamped
// and loaded into the output register in the same cycle.
module conv_mac_stream #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int FRAC  = 7,
  parameter int TAPS  = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_rnd_en,
  input  logic             i_tap_valid,
  output logic             o_tap_ready,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [WGT_W-1:0] i_wgt,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PIX_W-1:0] o_result,
  output logic             o_sat,
  output logic             o_busy
);

  localparam int ACC_W = PIX_W + WGT_W + 1 + $clog2(TAPS);
  localparam int PRD_W = PIX_W + WGT_W + 1;
  localparam int CNT_W = $clog2(TAPS);
  localparam int RND_W = ACC_W + 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic signed [RND_W-1:0] MAX_V    = RND_W'((2 ** PIX_W) - 1);
  localparam logic signed [RND_W-1:0] HALF_V   = RND_W'(2 ** (FRAC - 1));

  // Tap/product stage state
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [PRD_W-1:0] prod_q, prod_d;
  logic                    pv_q;
  logic                    first_q;
  logic                    last_q;
  logic                    rnd_q;
  // Accumulator
  logic signed [ACC_W-1:0] acc_q;
  // Output register
  logic                    valid_q;
  logic [PIX_W-1:0]        result_q, result_d;
  logic                    sat_q, sat_d;

  logic                    en;
  logic                    tap_acc;
  logic                    fin;
  logic signed [PRD_W-1:0] pix_s, wgt_s;
  logic signed [ACC_W-1:0] prod_ext, sum;
  logic signed [RND_W-1:0] sum_w, shifted;

  assign en          = !(valid_q && !i_ready);
  assign o_tap_ready = en;
  assign tap_acc     = i_tap_valid && en && !i_clr;
  // The abort wins over finishing a window whose last product is in flight.
  assign fin         = pv_q && last_q && en && !i_clr;

  // Pixel is zero-extended so it stays non-negative in the signed product.
  assign pix_s     = PRD_W'($signed({1'b0, i_pix}));
  assign wgt_s     = PRD_W'($signed(i_wgt));
  assign prod_d    = pix_s * wgt_s;
  assign tap_cnt_d = (tap_cnt_q == LAST_CNT) ? '0 : tap_cnt_q + CNT_W'(1);

  // Running sum including the product consumed this cycle, then round/shift.
  assign prod_ext = ACC_W'(prod_q);
  assign sum      = first_q ? prod_ext : acc_q + prod_ext;
  assign sum_w    = RND_W'(sum) + (rnd_q ? HALF_V : '0);
  assign shifted  = sum_w >>> FRAC;

  // Clamp the shifted value into the unsigned pixel range.
  always_comb begin
    result_d = shifted[PIX_W-1:0];
    sat_d    = 1'b0;
    if (shifted < 0) begin
      result_d = '0;
      sat_d    = 1'b1;
    end else if (shifted > MAX_V) begin
      result_d = '1;
      sat_d    = 1'b1;
    end
  end

  // Tap counter and product register; abort clears them before any accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tap_cnt_q <= '0;
      prod_q    <= '0;
      pv_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      rnd_q     <= 1'b0;
    end else if (i_clr) begin
      tap_cnt_q <= '0;
      pv_q      <= 1'b0;
    end else if (en) begin
      pv_q <= tap_acc;
      if (tap_acc) begin
        prod_q    <= prod_d;
        first_q   <= (tap_cnt_q == '0);
        last_q    <= (tap_cnt_q == LAST_CNT);
        tap_cnt_q <= tap_cnt_d;
        if (tap_cnt_q == '0) rnd_q <= i_rnd_en;
      end
    end
  end

  // Accumulator folds each product as it leaves the product register.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      acc_q <= '0;
    end else if (en && pv_q) begin
      acc_q <= sum;
    end
  end

  // Output register: load on finalise, otherwise drain on a taken result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (fin) begin
      valid_q  <= 1'b1;
      result_q <= result_d;
      sat_q    <= sat_d;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_sat    = sat_q;
  assign o_busy   = (tap_cnt_q != '0) || pv_q;

endmodule

// File: doc/conv_mac_stream.md
# conv_mac_stream

Parametrised, streaming multiply-accumulate convolution engine. It generalises the fixed combinational 3x3 window convolver to an arbitrary tap count and arbitrary pixel/weight widths. Taps arrive serially under a valid/ready handshake, and each window produces one clamped, rounded pixel through an output valid/ready register. It sits between the line-buffer/window fetch logic and the output image writer, and trades throughput (one tap per cycle) for a single multiplier.

## Interface
- PIX_W, 8, pixel width (unsigned) and result width
- WGT_W, 8, weight width (signed, two's complement)
- FRAC, 7, weight fractional bits (Q(WGT_W-FRAC).FRAC); FRAC >= 1
- TAPS, 9, taps per window; TAPS >= 2
- ACC_W (localparam), PIX_W+WGT_W+1+$clog2(TAPS), accumulator width (21 at defaults)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_clr  in  1  synchronous abort of the partially accumulated window
- i_rnd_en  in  1  1 = round half up, 0 = truncate (floor)
- i_tap_valid  in  1  tap presented
- o_tap_ready  out  1  engine accepts tap
- i_pix  in  PIX_W  unsigned pixel
- i_wgt  in  WGT_W  signed weight
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  PIX_W  clamped result
- o_sat  out  1  result was clamped (valid with o_valid)
- o_busy  out  1  window partially accumulated or product in flight

## Operation
- Global enable: en = !(o_valid && !i_ready). o_tap_ready = en. When en=0, every stage holds its value.
- Tap accept (i_tap_valid && o_tap_ready):
  - Registers prod = $signed({1'b0,i_pix}) * $signed(i_wgt) (PIX_W+WGT_W+1 bits).
  - Registers a first flag (tap_cnt==0) and a last flag (tap_cnt==TAPS-1).
  - tap_cnt increments and wraps TAPS-1 -> 0.
  - i_rnd_en is sampled with the first tap of each window. Changes mid-window have no effect.
- Accumulate stage (product valid && en):
  - acc <= first ? sext(prod) : acc + sext(prod), ACC_W signed.
- Finalise: on the cycle the last product is consumed, the engine forms s = (first ? prod : acc + prod) combinationally.
  - rounding on: r = (s + 2^(FRAC-1)) >>> FRAC.
  - rounding off: r = s >>> FRAC.
  - Clamp: r<0 -> 0 with o_sat=1; r>2^PIX_W-1 -> 2^PIX_W-1 with o_sat=1; otherwise r[PIX_W-1:0] with o_sat=0.
  - The result is registered into o_result/o_sat and o_valid is set.
- Output register: o_valid clears on (o_valid && i_ready) unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- While o_valid && !i_ready, o_result and o_sat are held stable.
- i_clr:
  - Zeroes tap_cnt, the product-valid bit and acc. Any tap presented in the same cycle is dropped.
  - Does not touch the output register (o_valid, o_result and o_sat are unaffected).
  - Has priority over tap accept.
- o_busy = (tap_cnt != 0) || product-valid.
- i_rst: all state to zero, i.e. o_valid=0, o_result=0, o_sat=0, o_busy=0, tap_cnt=0, acc=0. o_tap_ready=1 from the first cycle after reset.

## Timing
- Latency: last tap accepted at edge E0; o_valid high after edge E1 (2-cycle tap-to-result).
- Throughput: one tap per cycle; back-to-back windows with no bubble. One result every TAPS cycles with i_ready held high.
- Backpressure: o_tap_ready may only fall in the cycle after o_valid rises with i_ready low. No tap or product is lost or duplicated during a stall.
- Reset mid-window or mid-stall: next cycle is fully idle. No partial result is emitted.
- Simultaneous i_clr and result pop: the pop completes normally.

## Test plan
- Reset: assert i_rst 2 cycles during activity -> o_valid=0, o_result=0, o_sat=0, o_busy=0, o_tap_ready=1.
- Rounding: window with tap0 pix=1, wgt=64, other 8 taps wgt=0. With i_rnd_en=1 -> o_result=1, o_sat=0. With i_rnd_en=0 -> o_result=0. Result appears 2 cycles after the last tap.
- Saturation high/low:
  - all pix=255, wgt=127 (sum 291465) -> o_result=255, o_sat=1.
  - all pix=10, wgt=-128 (sum -11520) -> o_result=0, o_sat=1.
- Identity: centre tap pix=200, wgt=127, others wgt=0, rounding on -> o_result=198, o_sat=0.
- Backpressure: stream 3 windows continuously with i_ready low for 5 cycles after the first result -> o_tap_ready low during the stall. Results are correct and in order, with no dropped taps.
- Abort: 4 taps, then i_clr, then a full window (pix=2, wgt=64 on all taps) -> exactly one result, o_result=9. The earlier taps have no influence.
